// File: rtl/irq_pkg.sv
// irq_pkg: shared types, register map and helpers for the interrupt controller
//   irq_state_e : controller FSM states
//   ADDR_*      : register addresses on the reg_addr bus
//   cause_w()   : cause index width for a given source count (minimum 1)
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACTIVE
    } irq_state_e;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_MTVEC   = 2'd2;
    localparam logic [1:0] ADDR_EPC     = 2'd3;

    function automatic int cause_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: register bus and trap handshake between core and interrupt controller
//   reg_wr/reg_addr/reg_wdata : register write port (core -> ctrl)
//   reg_rdata                 : combinational register read (ctrl -> core)
//   irq_req/irq_cause         : trap request and source index (ctrl -> core)
//   irq_ack/pc_in             : trap commit and interrupted PC (core -> ctrl)
//   mret                      : return from trap (core -> ctrl)
//   epc/trap_vec              : saved PC and vectored target (ctrl -> core)
interface irq_ctrl_if #(
    parameter int NUM_SRC = 4,
    parameter int XLEN    = 32
);
    import irq_pkg::*;

    localparam int CAUSE_W = cause_w(NUM_SRC);

    logic               reg_wr;
    logic [1:0]         reg_addr;
    logic [XLEN-1:0]    reg_wdata;
    logic [XLEN-1:0]    reg_rdata;
    logic               irq_req;
    logic [CAUSE_W-1:0] irq_cause;
    logic               irq_ack;
    logic [XLEN-1:0]    pc_in;
    logic               mret;
    logic [XLEN-1:0]    epc;
    logic [XLEN-1:0]    trap_vec;

    modport master (
        output reg_wr, reg_addr, reg_wdata, irq_ack, pc_in, mret,
        input  reg_rdata, irq_req, irq_cause, epc, trap_vec
    );

    modport slave (
        input  reg_wr, reg_addr, reg_wdata, irq_ack, pc_in, mret,
        output reg_rdata, irq_req, irq_cause, epc, trap_vec
    );

endinterface

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-wins priority encoder
//   i_vec   : request vector
//   o_valid : any request present
//   o_idx   : index of the lowest set bit (0 when none)
module irq_prio_enc #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_vec,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    assign o_valid = |i_vec;

    // Scan downwards so the lowest set index is the last one assigned.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (i_vec[i]) o_idx = IDX_W'(i);
    end

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt/trap controller with per-source edge/level mode and fixed priority
//   clk, rst  : clock, synchronous active-high reset
//   i_src     : raw interrupt lines, synchronous to clk
//   i_glb_en  : global interrupt enable
//   bus       : register port and trap handshake (irq_ctrl_if.slave)
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int                 NUM_SRC   = 4,
    parameter int                 XLEN      = 32,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = NUM_SRC'(1),
    parameter logic [XLEN-1:0]    MTVEC_RST = XLEN'(32'h0000_0100)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] i_src,
    input  logic               i_glb_en,
    irq_ctrl_if.slave          bus
);

    localparam int CAUSE_W = cause_w(NUM_SRC);

    irq_state_e         r_state, w_state_nxt;
    logic [NUM_SRC-1:0] r_src_q, r_pend, r_en;
    logic [NUM_SRC-1:0] w_act, w_clr, w_cause_oh, w_pend_nxt;
    logic [XLEN-1:0]    r_mtvec, r_epc;
    logic [CAUSE_W-1:0] r_cause, w_win;
    logic               w_any, w_ack, w_cause_live;

    assign w_act        = r_pend & r_en;
    assign w_ack        = (r_state == REQ) && bus.irq_ack;
    assign w_cause_oh   = NUM_SRC'(1) << r_cause;
    assign w_cause_live = |(w_act & w_cause_oh);

    // W1C and ack clear only matter on edge bits; a fresh rising edge overrides the clear.
    assign w_clr = ((bus.reg_wr && bus.reg_addr == ADDR_PENDING) ? bus.reg_wdata[NUM_SRC-1:0] : '0)
                 | (w_ack ? w_cause_oh : '0);
    assign w_pend_nxt = (EDGE_MASK & ((i_src & ~r_src_q) | (r_pend & ~w_clr)))
                      | (~EDGE_MASK & i_src);

    irq_prio_enc #(
        .N    (NUM_SRC),
        .IDX_W(CAUSE_W)
    ) u_enc (
        .i_vec  (w_act),
        .o_valid(w_any),
        .o_idx  (w_win)
    );

    // Cause is frozen while in REQ; ack takes precedence over withdrawal.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_glb_en && w_any) w_state_nxt = REQ;
            REQ:     if (bus.irq_ack) w_state_nxt = ACTIVE;
                     else if (!i_glb_en || !w_cause_live) w_state_nxt = IDLE;
            ACTIVE:  if (bus.mret) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_src_q <= '0;
            r_pend  <= '0;
            r_en    <= '0;
            r_cause <= '0;
            r_epc   <= '0;
            r_mtvec <= {MTVEC_RST[XLEN-1:2], 2'b00};
        end else begin
            r_state <= w_state_nxt;
            r_src_q <= i_src;
            r_pend  <= w_pend_nxt;
            if (r_state == IDLE && w_state_nxt == REQ) r_cause <= w_win;
            if (w_ack) r_epc <= bus.pc_in;
            if (bus.reg_wr && bus.reg_addr == ADDR_ENABLE) r_en <= bus.reg_wdata[NUM_SRC-1:0];
            if (bus.reg_wr && bus.reg_addr == ADDR_MTVEC) r_mtvec <= {bus.reg_wdata[XLEN-1:2], 2'b00};
        end
    end

    assign bus.irq_req   = r_state == REQ;
    assign bus.irq_cause = r_cause;
    assign bus.epc       = r_epc;
    assign bus.trap_vec  = r_mtvec + (XLEN'(r_cause) << 2);
    assign bus.reg_rdata = bus.reg_addr == ADDR_ENABLE  ? XLEN'(r_en)   :
                           bus.reg_addr == ADDR_PENDING ? XLEN'(r_pend) :
                           bus.reg_addr == ADDR_MTVEC   ? r_mtvec       : r_epc;

endmodule
